sensor_frame_scheduler: RTL

Sequences whole-frame captures of the pixel sensor top level. It holds the sensor in reset between frames, releases it on request, and gates the output-buffer shift clock against downstream back-pressure. It counts output words, then closes each frame with a done pulse, a frame counter and error flags. It sits between host/control logic and the sensor top, driving that block's reset and buffer-clock enable and consuming its frame-finished and output-strobe signals.

---
 rtl/sensor_frame_scheduler_pkg.sv | 25 ++
 rtl/sensor_frame_scheduler_strobe_edge_detect.sv | 22 ++
 rtl/sensor_frame_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sensor_frame_scheduler_pkg.sv
// Shared configuration for the pixel sensor slice: array geometry, words per frame
// and the frame scheduler state encoding.
package sensor_frame_scheduler_pkg;

    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int PIXEL_ARRAY_WIDTH  = 2;
    localparam int OUTPUT_BUS_WIDTH   = 2;

    localparam int WORDS_PER_FRAME = PIXEL_ARRAY_HEIGHT * PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WORD_INDEX_W = index_width(WORDS_PER_FRAME);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/sensor_frame_scheduler_strobe_edge_detect.sv
// Rising-edge detector: compares a signal that is already synchronous to clk
// against its registered copy.
module sensor_frame_scheduler_strobe_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/sensor_frame_scheduler.sv
// Whole-frame capture sequencer for the pixel sensor top: holds the sensor in reset
// between frames, counts output words and closes each frame with done/count/error flags.
module sensor_frame_scheduler
    import sensor_frame_scheduler_pkg::*;
#(
    parameter int ROWS           = PIXEL_ARRAY_HEIGHT,
    parameter int COLS           = PIXEL_ARRAY_WIDTH,
    parameter int BUS_WIDTH      = OUTPUT_BUS_WIDTH,
    parameter int ARM_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FRAME_COUNT_W  = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    input  logic                                            continuous,
    input  logic                                            abort,
    input  logic                                            sink_ready,
    input  logic                                            sensor_frame_finished,
    input  logic                                            sensor_output_clk,
    output logic                                            sensor_reset,
    output logic                                            buffer_clk_en,
    output logic                                            word_valid,
    output logic [index_width(ROWS*COLS/BUS_WIDTH)-1:0]     word_index,
    output logic                                            busy,
    output logic                                            frame_done,
    output logic [FRAME_COUNT_W-1:0]                        frame_count,
    output logic                                            overrun,
    output logic                                            timeout
);

    localparam int WORDS = ROWS * COLS / BUS_WIDTH;
    localparam int IDX_W = index_width(WORDS);
    localparam int CNT_W = index_width(WORDS + 1);
    localparam int WD_W  = index_width(TIMEOUT_CYCLES);
    localparam int ARM_W = index_width(ARM_CYCLES);

    sched_state_t     state, state_next;
    logic [ARM_W-1:0] arm_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             strobe;
    logic             word_room;
    logic             frame_complete;
    logic             wd_expired;

    sensor_frame_scheduler_strobe_edge_detect u_strobe_edge_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sensor_output_clk),
        .rise  (strobe)
    );

    assign word_room      = (word_cnt < CNT_W'(WORDS));
    assign frame_complete = (state == RUN) && sensor_frame_finished && (word_cnt == CNT_W'(WORDS));
    assign wd_expired     = (state == RUN) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first, so no path through the case leaves state_next
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = ARM;
                ARM:  if (arm_cnt == '0) state_next = RUN;
                RUN: begin
                    if (frame_complete) begin
                        state_next = DONE;
                    end else if (wd_expired) begin
                        state_next = IDLE;
                    end
                end
                DONE:    state_next = continuous ? ARM : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        sensor_reset = (state != RUN);
        busy         = (state != IDLE);
        frame_done   = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt       <= '0;
            word_cnt      <= '0;
            wd_cnt        <= '0;
            word_valid    <= 1'b0;
            word_index    <= '0;
            buffer_clk_en <= 1'b0;
            frame_count   <= '0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            word_valid    <= 1'b0;
            buffer_clk_en <= (state_next == RUN) && sink_ready;
            if (abort) begin
                // Flags survive an abort so the host can still read why the frame died.
                arm_cnt    <= '0;
                word_cnt   <= '0;
                wd_cnt     <= '0;
                word_index <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            overrun    <= 1'b0;
                            timeout    <= 1'b0;
                            arm_cnt    <= ARM_W'(ARM_CYCLES - 1);
                            word_index <= '0;
                        end
                    end
                    ARM: begin
                        word_cnt <= '0;
                        wd_cnt   <= '0;
                        if (arm_cnt != '0) arm_cnt <= arm_cnt - 1'b1;
                    end
                    RUN: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_expired && !frame_complete) timeout <= 1'b1;
                        if (strobe && !sink_ready) overrun <= 1'b1;
                        if (strobe) begin
                            if (word_room) begin
                                word_valid <= 1'b1;
                                word_index <= word_cnt[IDX_W-1:0];
                                word_cnt   <= word_cnt + 1'b1;
                            end else begin
                                timeout <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        frame_count <= frame_count + 1'b1;
                        word_cnt    <= '0;
                        wd_cnt      <= '0;
                        if (continuous) begin
                            arm_cnt    <= ARM_W'(ARM_CYCLES - 1);
                            word_index <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
